address_decode_pipe: RTL and testbench



---
 rtl/address_decode_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_address_decode_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/address_decode_pipe.sv
// address_decode_pipe: two-stage registered SNES address decoder.
// Stage 1 captures the bus address, PA and ROMSEL on SNES_ADDR_STROBE.
// Stage 2 registers the LoROM/HiROM decode, the peripheral selects and the
// trap hits. A three-process FSM sequences map unlock with a release hold.
// Build option: define ADDR_TRAP_EN to get the programmable exact-match trap
// table. Without it, trap_hit is tied to 0 and no trap state exists.
module address_decode_pipe #(
  parameter int          NUM_TRAPS   = 4,
  parameter int          UNLOCK_HOLD = 8,
  parameter logic [23:0] SRAM_BASE   = 24'hE00000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [23:0]          SNES_ADDR,
  input  logic [7:0]           SNES_PA,
  input  logic                 SNES_ROMSEL,
  input  logic                 SNES_ADDR_STROBE,
  input  logic [2:0]           MAPPER,
  input  logic [7:0]           featurebits,
  input  logic [23:0]          SAVERAM_MASK,
  input  logic [23:0]          ROM_MASK,
  input  logic                 unlock_req,
  input  logic                 unlock_release,
  input  logic                 trap_wr,
  input  logic [3:0]           trap_idx,
  input  logic [23:0]          trap_addr,
  input  logic                 trap_valid,
  output logic [23:0]          ROM_ADDR,
  output logic                 ROM_HIT,
  output logic                 IS_ROM,
  output logic                 IS_SAVERAM,
  output logic                 IS_WRITABLE,
  output logic                 msu_enable,
  output logic                 r213f_enable,
  output logic                 cx4_enable,
  output logic [NUM_TRAPS-1:0] trap_hit,
  output logic                 map_unlock,
  output logic                 decode_valid
);

  localparam int CW = (UNLOCK_HOLD < 1) ? 1 : $clog2(UNLOCK_HOLD + 1);

  typedef enum logic [1:0] {LOCKED, UNLOCKED, DRAIN} ustate_t;

  ustate_t       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Valid shift register: [0] is the live strobe, [2] is decode_valid.
  logic [2:0]    vld_pipe;
  logic [1:0]    vld_q;
  assign vld_pipe = {vld_q, SNES_ADDR_STROBE};
  assign decode_valid = vld_pipe[2];

  logic [23:0]   s1_addr;
  logic [7:0]    s1_pa;
  logic          s1_romsel;

  // Unlock FSM state and hold counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= LOCKED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Unlock FSM next state; a request always beats a release.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOCKED: begin
        if (unlock_req) state_nxt = UNLOCKED;
      end
      UNLOCKED: begin
        if (!unlock_req && unlock_release) begin
          if (UNLOCK_HOLD == 0) begin
            state_nxt = LOCKED;
          end else begin
            state_nxt = DRAIN;
            cnt_nxt   = CW'(UNLOCK_HOLD);
          end
        end
      end
      DRAIN: begin
        if (unlock_req) begin
          state_nxt = UNLOCKED;
          cnt_nxt   = '0;
        end else if (cnt <= CW'(1)) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = LOCKED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Unlock FSM output: unlocked throughout the hold window.
  always_comb begin
    map_unlock = (state != LOCKED);
  end

  // Stage 1: capture bus fields on strobe and advance the valid pipe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q     <= '0;
      s1_addr   <= '0;
      s1_pa     <= '0;
      s1_romsel <= 1'b0;
    end else begin
      vld_q <= vld_pipe[1:0];
      if (vld_pipe[0]) begin
        s1_addr   <= SNES_ADDR;
        s1_pa     <= SNES_PA;
        s1_romsel <= SNES_ROMSEL;
      end
    end
  end

  // Decode of the stage-1 address with the live mapper, masks and unlock.
  logic        lorom, sav_lo, sav_hi, is_rom_c, is_sav_c, patch_c, wr_c;
  logic        msu_c, cx4_c, r213f_c;
  logic [23:0] rom_lo_a, rom_hi_a, sav_lo_a, sav_hi_a, addr_c;

  always_comb begin
    lorom    = (MAPPER != 3'd1);
    is_rom_c = s1_addr[22] | s1_addr[15];
    sav_lo   = ~s1_addr[23] & (s1_addr[22:20] == 3'h7) & ~s1_addr[19] & ~s1_addr[15];
    sav_hi   = ~s1_addr[22] & s1_addr[21] & (s1_addr[14:13] == 2'b11);
    is_sav_c = (lorom ? sav_lo : sav_hi) & (|SAVERAM_MASK) & ~map_unlock;
    rom_lo_a = {2'b00, s1_addr[22:16], s1_addr[14:0]} & ROM_MASK;
    rom_hi_a = {2'b00, s1_addr[21:0]} & ROM_MASK;
    sav_lo_a = SRAM_BASE | ({5'b0, s1_addr[19:16], s1_addr[14:0]} & SAVERAM_MASK);
    sav_hi_a = SRAM_BASE | ({6'b0, s1_addr[20:16], s1_addr[12:0]} & SAVERAM_MASK);
    // Unlocked bank $F0-$FF passes straight through for patch writes.
    patch_c  = map_unlock & (s1_addr[23:20] == 4'hF);
    if (patch_c)       addr_c = s1_addr;
    else if (is_sav_c) addr_c = lorom ? sav_lo_a : sav_hi_a;
    else               addr_c = lorom ? rom_lo_a : rom_hi_a;
    wr_c     = is_sav_c | (map_unlock & ((s1_addr[23:20] == 4'hF) | ~s1_romsel));
    msu_c    = featurebits[3] & ~s1_addr[22] & ((s1_addr[15:0] & 16'hFFF8) == 16'h2000);
    cx4_c    = lorom & ~s1_addr[22] & (s1_addr[15:13] == 3'b011);
    r213f_c  = featurebits[4] & (s1_pa == 8'h3F);
  end

  // Stage 2: register decoded outputs; they hold between updates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ROM_ADDR     <= '0;
      ROM_HIT      <= 1'b0;
      IS_ROM       <= 1'b0;
      IS_SAVERAM   <= 1'b0;
      IS_WRITABLE  <= 1'b0;
      msu_enable   <= 1'b0;
      r213f_enable <= 1'b0;
      cx4_enable   <= 1'b0;
    end else if (vld_pipe[1]) begin
      ROM_ADDR     <= addr_c;
      ROM_HIT      <= is_rom_c | wr_c;
      IS_ROM       <= is_rom_c;
      IS_SAVERAM   <= is_sav_c;
      IS_WRITABLE  <= wr_c;
      msu_enable   <= msu_c;
      r213f_enable <= r213f_c;
      cx4_enable   <= cx4_c;
    end
  end

`ifdef ADDR_TRAP_EN
  logic [NUM_TRAPS-1:0][23:0] trap_tab;
  logic [NUM_TRAPS-1:0]       trap_en;
  logic [NUM_TRAPS-1:0]       s1_trap;

  // Trap table writes; out-of-range indices match no entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      trap_tab <= '0;
      trap_en  <= '0;
    end else if (trap_wr) begin
      for (int i = 0; i < NUM_TRAPS; i++) begin
        if (trap_idx == 4'(i)) begin
          trap_tab[i] <= trap_addr;
          trap_en[i]  <= trap_valid;
        end
      end
    end
  end

  // Trap compares ride stage 1 (pre-write table), results land in stage 2.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_trap  <= '0;
      trap_hit <= '0;
    end else begin
      if (vld_pipe[0]) begin
        for (int i = 0; i < NUM_TRAPS; i++)
          s1_trap[i] <= trap_en[i] & (SNES_ADDR == trap_tab[i]);
      end
      if (vld_pipe[1]) trap_hit <= s1_trap;
    end
  end

  logic unused_fb;
  assign unused_fb = ^{featurebits[7:5], featurebits[2:0]};
`else
  assign trap_hit = '0;

  logic unused_trap;
  assign unused_trap = ^{trap_wr, trap_idx, trap_addr, trap_valid,
                         featurebits[7:5], featurebits[2:0]};
`endif

endmodule

// File: tb/tb_address_decode_pipe.sv
// Bench for address_decode_pipe: vector table plus hand-written unlock,
// trap, back-to-back and mid-pipeline reset sequences; results checked
// through a scoreboard queue on every decode_valid.
module tb_address_decode_pipe;
  localparam int NT   = 4;
  localparam int HOLD = 8;
`ifdef ADDR_TRAP_EN
  localparam logic [NT-1:0] TRAP2 = 4'b0100;
`else
  localparam logic [NT-1:0] TRAP2 = 4'b0000;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [23:0]   SNES_ADDR = '0;
  logic [7:0]    SNES_PA = '0;
  logic          SNES_ROMSEL = 1'b1;
  logic          SNES_ADDR_STROBE = 1'b0;
  logic [2:0]    MAPPER = '0;
  logic [7:0]    featurebits = '0;
  logic [23:0]   SAVERAM_MASK = '0;
  logic [23:0]   ROM_MASK = '0;
  logic          unlock_req = 1'b0, unlock_release = 1'b0;
  logic          trap_wr = 1'b0, trap_valid = 1'b0;
  logic [3:0]    trap_idx = '0;
  logic [23:0]   trap_addr = '0;
  logic [23:0]   ROM_ADDR;
  logic          ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE;
  logic          msu_enable, r213f_enable, cx4_enable, map_unlock, decode_valid;
  logic [NT-1:0] trap_hit;

  address_decode_pipe #(.NUM_TRAPS(NT), .UNLOCK_HOLD(HOLD), .SRAM_BASE(24'hE00000)) dut (
    .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .SNES_PA(SNES_PA),
    .SNES_ROMSEL(SNES_ROMSEL), .SNES_ADDR_STROBE(SNES_ADDR_STROBE), .MAPPER(MAPPER),
    .featurebits(featurebits), .SAVERAM_MASK(SAVERAM_MASK), .ROM_MASK(ROM_MASK),
    .unlock_req(unlock_req), .unlock_release(unlock_release), .trap_wr(trap_wr),
    .trap_idx(trap_idx), .trap_addr(trap_addr), .trap_valid(trap_valid),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_ROM(IS_ROM), .IS_SAVERAM(IS_SAVERAM),
    .IS_WRITABLE(IS_WRITABLE), .msu_enable(msu_enable), .r213f_enable(r213f_enable),
    .cx4_enable(cx4_enable), .trap_hit(trap_hit), .map_unlock(map_unlock),
    .decode_valid(decode_valid)
  );

  always #5 CLK = ~CLK;

  // flags order: {ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE, msu, r213f, cx4}
  logic [6:0] flags_o;
  assign flags_o = {ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE, msu_enable, r213f_enable, cx4_enable};

  typedef struct {
    logic [23:0]   addr;
    logic [6:0]    flags;
    logic [NT-1:0] trap;
  } exp_t;

  typedef struct {
    logic [2:0]  mapper;
    logic [23:0] a;
    logic [7:0]  pa;
    logic        romsel;
    logic [7:0]  fb;
    logic [23:0] smask;
    logic [23:0] rmask;
    logic [23:0] e_addr;
    logic [6:0]  e_flags;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Scoreboard: every decode_valid pops one expected record.
  exp_t got;
  always @(negedge CLK) begin
    if (RST_N && decode_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        got = sbq.pop_front();
        chk("rom_addr", 32'(ROM_ADDR), 32'(got.addr));
        chk("flags", 32'(flags_o), 32'(got.flags));
        chk("trap_hit", 32'(trap_hit), 32'(got.trap));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input vec_t v);
    MAPPER = v.mapper; SNES_PA = v.pa; SNES_ROMSEL = v.romsel;
    featurebits = v.fb; SAVERAM_MASK = v.smask; ROM_MASK = v.rmask;
  endtask

  task automatic strobe(input logic [23:0] a, input logic [23:0] ea,
                        input logic [6:0] ef, input logic [NT-1:0] et);
    exp_t e;
    e.addr = ea; e.flags = ef; e.trap = et;
    SNES_ADDR = a; SNES_ADDR_STROBE = 1'b1;
    sbq.push_back(e);
    @(posedge CLK); #1;
    SNES_ADDR_STROBE = 1'b0;
  endtask

  task automatic pulse(input logic req, input logic rel);
    unlock_req = req; unlock_release = rel;
    @(posedge CLK); #1;
    unlock_req = 1'b0; unlock_release = 1'b0;
  endtask

  // Release at cycle N: map_unlock high through N+HOLD, low at N+1+HOLD.
  task automatic drain_check(input string name);
    pulse(1'b0, 1'b1);
    for (int k = 1; k <= HOLD + 1; k++) begin
      chk(name, 32'(map_unlock), (k <= HOLD) ? 32'd1 : 32'd0);
      if (k < HOLD + 1) idle(1);
    end
  endtask

  task automatic hold_check(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      chk(name, 32'(map_unlock), 32'd1);
      idle(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  vec_t cfg;

  initial begin
    //          map   addr        pa     rs    fb     smask        rmask        exp addr     exp flags
    vecs[0] = '{3'd0, 24'h80ABCD, 8'h00, 1'b0, 8'h00, 24'h001FFF, 24'h3FFFFF, 24'h002BCD, 7'b1100000};
    vecs[1] = '{3'd0, 24'h701234, 8'h00, 1'b1, 8'h00, 24'h001FFF, 24'h3FFFFF, 24'hE01234, 7'b1111000};
    vecs[2] = '{3'd1, 24'h206010, 8'h00, 1'b1, 8'h00, 24'h001FFF, 24'h3FFFFF, 24'hE00010, 7'b1011000};
    vecs[3] = '{3'd1, 24'hC12345, 8'h00, 1'b0, 8'h00, 24'h001FFF, 24'h3FFFFF, 24'h012345, 7'b1100000};
    vecs[4] = '{3'd0, 24'h006000, 8'h3F, 1'b1, 8'h18, 24'h001FFF, 24'h3FFFFF, 24'h006000, 7'b0000011};
    vecs[5] = '{3'd0, 24'h9FFFFF, 8'h00, 1'b0, 8'h18, 24'h001FFF, 24'h07FFFF, 24'h07FFFF, 7'b1100000};
    vecs[6] = '{3'd0, 24'h701234, 8'h00, 1'b1, 8'h00, 24'h000000, 24'h3FFFFF, 24'h381234, 7'b1100000};
    vecs[7] = '{3'd1, 24'h3F7ABC, 8'h00, 1'b1, 8'h00, 24'h03FFFF, 24'h3FFFFF, 24'hE3FABC, 7'b1011000};
    vecs[8] = '{3'd5, 24'h80ABCD, 8'h00, 1'b0, 8'h00, 24'h001FFF, 24'h3FFFFF, 24'h002BCD, 7'b1100000};
    vecs[9] = '{3'd0, 24'h006000, 8'h3F, 1'b1, 8'h08, 24'h001FFF, 24'h3FFFFF, 24'h006000, 7'b0000001};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rom_addr", 32'(ROM_ADDR), 32'h0);
    chk("rst_flags", 32'(flags_o), 32'h0);
    chk("rst_trap", 32'(trap_hit), 32'h0);
    chk("rst_valid", 32'(decode_valid), 32'h0);
    RST_N = 1'b1;
    idle(1);
    chk("rst_unlock", 32'(map_unlock), 32'h0);

    // Latency: strobe at N, decode_valid exactly at N+2 for one cycle
    set_cfg(vecs[0]);
    strobe(vecs[0].a, vecs[0].e_addr, vecs[0].e_flags, '0);
    chk("lat_n1", 32'(decode_valid), 32'd0);
    idle(1);
    chk("lat_n2", 32'(decode_valid), 32'd1);
    idle(1);
    chk("lat_n3", 32'(decode_valid), 32'd0);
    idle(2);

    // Locked decode vector table
    for (int i = 0; i < 10; i++) begin
      set_cfg(vecs[i]);
      strobe(vecs[i].a, vecs[i].e_addr, vecs[i].e_flags, '0);
      idle(3);
    end

    // Back-to-back MSU window edge: one result per cycle
    cfg = '{3'd0, 24'h0, 8'h00, 1'b1, 8'h08, 24'h001FFF, 24'h3FFFFF, 24'h0, 7'b0};
    set_cfg(cfg);
    strobe(24'h002000, 24'h002000, 7'b0000100, '0);
    strobe(24'h002008, 24'h002008, 7'b0000000, '0);
    chk("b2b_v1", 32'(decode_valid), 32'd1);
    idle(1);
    chk("b2b_v2", 32'(decode_valid), 32'd1);
    idle(3);

    // Trap write in the strobe cycle uses the old entry; next strobe hits
    cfg = '{3'd0, 24'h0, 8'h00, 1'b1, 8'h00, 24'h001FFF, 24'h3FFFFF, 24'h0, 7'b0};
    set_cfg(cfg);
    trap_wr = 1'b1; trap_idx = 4'd2; trap_addr = 24'h002A5A; trap_valid = 1'b1;
    strobe(24'h002A5A, 24'h002A5A, 7'b0, '0);
    trap_idx = 4'd9; trap_addr = 24'h002A5B;
    strobe(24'h002A5A, 24'h002A5A, 7'b0, TRAP2);
    trap_wr = 1'b0;
    strobe(24'h002A5B, 24'h002A5B, 7'b0, '0);
    idle(3);

    // Unlock: req at N -> map_unlock at N+1
    chk("pre_unlock", 32'(map_unlock), 32'd0);
    pulse(1'b1, 1'b0);
    chk("unlock_n1", 32'(map_unlock), 32'd1);
    strobe(24'h701234, 24'h381234, 7'b1100000, '0);
    idle(3);
    strobe(24'hF01234, 24'hF01234, 7'b1101000, '0);
    idle(3);
    SNES_ROMSEL = 1'b0;
    strobe(24'h80ABCD, 24'h002BCD, 7'b1101000, '0);
    idle(3);
    SNES_ROMSEL = 1'b1;
    drain_check("drain_hold");

    // Request during drain restarts the unlock and clears the hold
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    idle(3);
    pulse(1'b1, 1'b0);
    hold_check("drain_reenter", HOLD + 3);
    drain_check("drain_after_reenter");

    // Simultaneous req and release from LOCKED: req wins
    idle(1);
    chk("locked_before_both", 32'(map_unlock), 32'd0);
    pulse(1'b1, 1'b1);
    hold_check("req_wins", HOLD + 3);

    // Reset mid-pipeline while unlocked and with nonzero outputs held
    SNES_ROMSEL = 1'b0;
    strobe(24'h80ABCD, 24'h002BCD, 7'b1101000, '0);
    idle(2);
    strobe(24'h80ABCD, 24'h002BCD, 7'b1101000, '0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_rom_addr", 32'(ROM_ADDR), 32'h0);
    chk("midrst_flags", 32'(flags_o), 32'h0);
    chk("midrst_unlock", 32'(map_unlock), 32'h0);
    chk("midrst_valid", 32'(decode_valid), 32'h0);
    sbq.delete();
    idle(2);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("post_rst_valid", 32'(decode_valid), 32'd0);
    end

    // Trap table cleared by reset
    SNES_ROMSEL = 1'b1;
    strobe(24'h002A5A, 24'h002A5A, 7'b0, '0);
    idle(4);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
